// File: rtl/umem_arbiter_if.sv
// Bus bundle between the unified-memory arbiter, its two requesters (IF, LS)
// and the umem port.
//   slave  : arbiter view (requests and mem_rdata in, grants/responses/mem strobes out)
//   master : environment view (core fetch/LSU plus umem model)
// Signals:
//   if_req/if_addr/if_gnt/if_rsp/if_rdata                      instruction fetch port
//   ls_req/ls_rw/ls_addr/ls_wdata/ls_wstrb/ls_gnt/ls_rsp/ls_rdata load/store port
//   mem_req/mem_rw/mem_addr/mem_wdata/mem_wstrb/mem_rdata       umem port
interface umem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rsp;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_rw;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [STRB_W-1:0] ls_wstrb;
    logic              ls_gnt;
    logic              ls_rsp;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_req;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rsp, if_rdata,
        input  ls_req, ls_rw, ls_addr, ls_wdata, ls_wstrb,
        output ls_gnt, ls_rsp, ls_rdata,
        output mem_req, mem_rw, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rsp, if_rdata,
        output ls_req, ls_rw, ls_addr, ls_wdata, ls_wstrb,
        input  ls_gnt, ls_rsp, ls_rdata,
        input  mem_req, mem_rw, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );
endinterface

// File: rtl/umem_arbiter.sv
// Unified-memory arbiter: shares one fixed-latency umem port between
// instruction fetch (IF) and load/store (LS). One transaction outstanding;
// the read data is registered and returned to the requester that issued it.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    umem_arbiter_if.slave (IF/LS request ports and the umem port)
// Grants and the mem_* request strobes are combinational in the grant cycle;
// rsp/rdata are registered.
module umem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned LS_PRIORITY = 0
) (
    input  logic            clk,
    input  logic            reset,
    umem_arbiter_if.slave   bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic              owner_ls;     // 1: outstanding transaction belongs to LS
    logic              rw_q;         // outstanding transaction is a write
    logic              last_gnt_ls;  // 1: most recent grant went to LS
    logic              gnt_if;
    logic              gnt_ls;
    logic              capture;
    logic              if_rsp_q;
    logic              ls_rsp_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, arbitration and umem request drive
    always_comb begin
        state_n       = state;
        gnt_if        = 1'b0;
        gnt_ls        = 1'b0;
        capture       = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_rw    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;

        case (state)
            // RESP accepts a new request exactly like IDLE so that
            // transactions can issue back to back.
            IDLE, RESP: begin
                state_n = IDLE;
                if (!reset && (bus.if_req || bus.ls_req)) begin
                    if (bus.if_req && bus.ls_req) begin
                        if ((LS_PRIORITY != 0) || !last_gnt_ls) begin
                            gnt_ls = 1'b1;
                        end else begin
                            gnt_if = 1'b1;
                        end
                    end else if (bus.if_req) begin
                        gnt_if = 1'b1;
                    end else begin
                        gnt_ls = 1'b1;
                    end
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    capture = 1'b1;
                    state_n = RESP;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (gnt_if) begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = bus.if_addr;
        end else if (gnt_ls) begin
            bus.mem_req  = 1'b1;
            bus.mem_rw   = bus.ls_rw;
            bus.mem_addr = bus.ls_addr;
            if (bus.ls_rw) begin
                bus.mem_wdata = bus.ls_wdata;
                bus.mem_wstrb = bus.ls_wstrb;
            end
        end
    end

    // Transaction bookkeeping, latency counter and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            owner_ls    <= 1'b0;
            rw_q        <= 1'b0;
            last_gnt_ls <= 1'b1;
            if_rsp_q    <= 1'b0;
            ls_rsp_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            if_rsp_q <= 1'b0;
            ls_rsp_q <= 1'b0;

            if (gnt_if || gnt_ls) begin
                cnt         <= CNT_W'(MEM_LATENCY);
                owner_ls    <= gnt_ls;
                rw_q        <= gnt_ls & bus.ls_rw;
                last_gnt_ls <= gnt_ls;
            end else if (state == BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end

            // Writes return zero data so ls_rdata never shows stale read data.
            if (capture) begin
                if (owner_ls) begin
                    ls_rsp_q   <= 1'b1;
                    ls_rdata_q <= rw_q ? '0 : bus.mem_rdata;
                end else begin
                    if_rsp_q   <= 1'b1;
                    if_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_gnt   = gnt_if;
    assign bus.ls_gnt   = gnt_ls;
    assign bus.if_rsp   = if_rsp_q;
    assign bus.ls_rsp   = ls_rsp_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_umem_arbiter.sv
// Directed bench for umem_arbiter: round-robin instance with a latency-2 umem
// model, plus an LS-priority instance for the starvation case.
module tb_umem_arbiter;
    localparam int unsigned MEM_LAT = 2;

    logic clk;
    logic reset;
    int   npass;
    int   ntotal;

    umem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    umem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();

    umem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(MEM_LAT), .LS_PRIORITY(0)) u_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    umem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(MEM_LAT), .LS_PRIORITY(1)) u_pri (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lookup(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hDEADBEEF;
            32'h20:  return 32'hCAFEF00D;
            32'h44:  return 32'h01234567;
            default: return 32'h0;
        endcase
    endfunction

    // umem model: read data appears exactly MEM_LAT cycles after mem_req, garbage otherwise
    logic [31:0] pipe [MEM_LAT];
    always @(posedge clk) begin
        pipe[0] <= (b1.mem_req && !b1.mem_rw) ? lookup(b1.mem_addr) : 32'hBAD0BAD0;
        for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign b1.mem_rdata = pipe[MEM_LAT-1];
    assign b2.mem_rdata = 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic idle1();
        b1.if_req = 1'b0; b1.if_addr = 32'h0;
        b1.ls_req = 1'b0; b1.ls_rw = 1'b0; b1.ls_addr = 32'h0;
        b1.ls_wdata = 32'h0; b1.ls_wstrb = 4'h0;
    endtask

    initial begin
        npass = 0;
        ntotal = 0;
        reset = 1'b1;
        idle1();
        b2.if_req = 1'b0; b2.if_addr = 32'h0;
        b2.ls_req = 1'b0; b2.ls_rw = 1'b0; b2.ls_addr = 32'h0;
        b2.ls_wdata = 32'h0; b2.ls_wstrb = 4'h0;
        b1.if_req = 1'b1; b1.if_addr = 32'h10;

        // Reset state; no grant while reset is high even with a request pending
        tick(); tick(); #1;
        chk("rst_if_gnt",   32'(b1.if_gnt),   32'h0);
        chk("rst_mem_req",  32'(b1.mem_req),  32'h0);
        chk("rst_mem_addr", b1.mem_addr,      32'h0);
        chk("rst_if_rsp",   32'(b1.if_rsp),   32'h0);
        chk("rst_if_rdata", b1.if_rdata,      32'h0);
        chk("rst_ls_rdata", b1.ls_rdata,      32'h0);
        chk("rst_pri_gnt",  32'(b2.ls_gnt),   32'h0);
        tick(); reset = 1'b0; idle1(); #1;
        chk("idle_mem_req", 32'(b1.mem_req),  32'h0);

        // T1: single IF read, response in cycle 3 only
        tick(); b1.if_req = 1'b1; b1.if_addr = 32'h10; #1;
        chk("t1_if_gnt",   32'(b1.if_gnt),  32'h1);
        chk("t1_mem_req",  32'(b1.mem_req), 32'h1);
        chk("t1_mem_addr", b1.mem_addr,     32'h10);
        chk("t1_mem_rw",   32'(b1.mem_rw),  32'h0);
        chk("t1_ls_gnt",   32'(b1.ls_gnt),  32'h0);
        tick(); b1.if_req = 1'b0; #1;
        chk("t1_c1_rsp",   32'(b1.if_rsp),  32'h0);
        chk("t1_c1_mreq",  32'(b1.mem_req), 32'h0);
        tick(); #1;
        chk("t1_c2_rsp",   32'(b1.if_rsp),  32'h0);
        tick(); #1;
        chk("t1_c3_rsp",   32'(b1.if_rsp),  32'h1);
        chk("t1_c3_rdata", b1.if_rdata,     32'hDEADBEEF);
        chk("t1_c3_lsrsp", 32'(b1.ls_rsp),  32'h0);
        tick(); #1;
        chk("t1_c4_rsp",   32'(b1.if_rsp),  32'h0);
        chk("t1_c4_hold",  b1.if_rdata,     32'hDEADBEEF);

        // T2: reset, then both request continuously -> IF, LS, IF at 0/3/6
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        tick(); b1.if_req = 1'b1; b1.if_addr = 32'h44;
        b1.ls_req = 1'b1; b1.ls_rw = 1'b0; b1.ls_addr = 32'h20; #1;
        chk("t2_c0_if_gnt", 32'(b1.if_gnt), 32'h1);
        chk("t2_c0_ls_gnt", 32'(b1.ls_gnt), 32'h0);
        chk("t2_c0_addr",   b1.mem_addr,    32'h44);
        tick(); #1;
        chk("t2_c1_gnt", 32'({b1.if_gnt, b1.ls_gnt}), 32'h0);
        tick(); #1;
        chk("t2_c2_gnt", 32'({b1.if_gnt, b1.ls_gnt}), 32'h0);
        tick(); #1;
        chk("t2_c3_ls_gnt", 32'(b1.ls_gnt), 32'h1);
        chk("t2_c3_if_gnt", 32'(b1.if_gnt), 32'h0);
        chk("t2_c3_addr",   b1.mem_addr,    32'h20);
        chk("t2_c3_if_rsp", 32'(b1.if_rsp), 32'h1);
        chk("t2_c3_rdata",  b1.if_rdata,    32'h01234567);
        tick(); tick(); tick(); #1;
        chk("t2_c6_if_gnt", 32'(b1.if_gnt), 32'h1);
        chk("t2_c6_ls_gnt", 32'(b1.ls_gnt), 32'h0);
        chk("t2_c6_ls_rsp", 32'(b1.ls_rsp), 32'h1);
        chk("t2_c6_ls_dat", b1.ls_rdata,    32'hCAFEF00D);
        tick(); idle1(); #1;
        chk("t2_c7_ls_rsp", 32'(b1.ls_rsp), 32'h0);
        tick(); tick(); #1;
        chk("t2_c9_if_rsp", 32'(b1.if_rsp), 32'h1);
        tick();

        // T3: LS write passthrough, zero read data on completion
        tick(); b1.ls_req = 1'b1; b1.ls_rw = 1'b1; b1.ls_addr = 32'h40;
        b1.ls_wdata = 32'h12345678; b1.ls_wstrb = 4'b0011; #1;
        chk("t3_ls_gnt", 32'(b1.ls_gnt),    32'h1);
        chk("t3_rw",     32'(b1.mem_rw),    32'h1);
        chk("t3_wstrb",  32'(b1.mem_wstrb), 32'h3);
        chk("t3_wdata",  b1.mem_wdata,      32'h12345678);
        chk("t3_addr",   b1.mem_addr,       32'h40);
        tick(); idle1(); #1;
        chk("t3_c1_wstrb", 32'(b1.mem_wstrb), 32'h0);
        tick(); tick(); #1;
        chk("t3_c3_ls_rsp", 32'(b1.ls_rsp), 32'h1);
        chk("t3_c3_ls_dat", b1.ls_rdata,    32'h0);
        chk("t3_c3_if_rsp", 32'(b1.if_rsp), 32'h0);
        chk("t3_c3_if_hld", b1.if_rdata,    32'h01234567);
        tick();

        // T4: reset in BUSY cycle 1 aborts the read; next request granted at once
        tick(); b1.if_req = 1'b1; b1.if_addr = 32'h10; #1;
        chk("t4_c0_gnt", 32'(b1.if_gnt), 32'h1);
        tick(); b1.if_req = 1'b0; reset = 1'b1;
        tick(); reset = 1'b0; #1;
        chk("t4_c2_rsp",    32'({b1.if_rsp, b1.ls_rsp}), 32'h0);
        chk("t4_c2_ifdat",  b1.if_rdata,  32'h0);
        chk("t4_c2_lsdat",  b1.ls_rdata,  32'h0);
        chk("t4_c2_mreq",   32'(b1.mem_req), 32'h0);
        b1.if_req = 1'b1; b1.if_addr = 32'h20; #1;
        chk("t4_c2_gnt",    32'(b1.if_gnt), 32'h1);
        tick(); b1.if_req = 1'b0; #1;
        chk("t4_c3_rsp", 32'(b1.if_rsp), 32'h0);
        tick(); #1;
        chk("t4_c4_rsp", 32'(b1.if_rsp), 32'h0);
        tick(); #1;
        chk("t4_c5_rsp",   32'(b1.if_rsp), 32'h1);
        chk("t4_c5_rdata", b1.if_rdata,    32'hCAFEF00D);
        tick();

        // T6: LS request arriving in BUSY waits for the RESP cycle
        tick(); b1.if_req = 1'b1; b1.if_addr = 32'h10; #1;
        chk("t6_c0_gnt", 32'(b1.if_gnt), 32'h1);
        tick(); b1.if_req = 1'b0; b1.ls_req = 1'b1; b1.ls_rw = 1'b0; b1.ls_addr = 32'h44; #1;
        chk("t6_c1_ls_gnt", 32'(b1.ls_gnt), 32'h0);
        tick(); #1;
        chk("t6_c2_ls_gnt", 32'(b1.ls_gnt), 32'h0);
        tick(); #1;
        chk("t6_c3_ls_gnt", 32'(b1.ls_gnt), 32'h1);
        chk("t6_c3_if_rsp", 32'(b1.if_rsp), 32'h1);
        chk("t6_c3_addr",   b1.mem_addr,    32'h44);
        chk("t6_c3_rdata",  b1.if_rdata,    32'hDEADBEEF);
        tick(); idle1(); tick(); tick(); #1;
        chk("t6_c6_ls_rsp", 32'(b1.ls_rsp), 32'h1);
        chk("t6_c6_ls_dat", b1.ls_rdata,    32'h01234567);

        // T5: LS priority instance, both requesting -> LS every 3 cycles, IF never
        tick(); b2.if_req = 1'b1; b2.if_addr = 32'h10;
        b2.ls_req = 1'b1; b2.ls_addr = 32'h20;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) tick();
            #1;
            chk($sformatf("t5_c%0d_ls_gnt", k), 32'(b2.ls_gnt), (k % 3 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("t5_c%0d_if_gnt", k), 32'(b2.if_gnt), 32'h0);
        end
        b2.if_req = 1'b0; b2.ls_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
